// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO pad I/O slice.
// The optional rising-edge interrupt is enabled by defining GPIO_EDGE_IRQ_EN.
package gpio_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } dbnc_state_t;

  localparam int GPIO_WIDTH_DEFAULT  = 32;
  localparam int DEBOUNCE_DEFAULT    = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // One spare bit so the terminal count always fits, even for DEBOUNCE_CYCLES=1.
  function automatic int dbnc_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Input path: multi-flop synchroniser followed by a whole-vector debounce FSM.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   STABLE | synchronised input matches the committed vector, nothing pending
//   SETTLE | a new candidate is being timed; any change restarts the count
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] stable,
  output logic             changed,
  output logic [WIDTH-1:0] rise
);

  localparam int CNT_W = dbnc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  dbnc_state_t      state;
  logic             commit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Commit happens on the edge where the candidate has held for the full window.
  assign commit = (state == SETTLE) && (sync_q == cand) && (cnt == CNT_LAST);
  assign rise   = commit ? (cand & ~stable) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= STABLE;
      cand    <= '0;
      cnt     <= '0;
      stable  <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      case (state)
        STABLE: begin
          if (sync_q != stable) begin
            cand  <= sync_q;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync_q != cand) begin
            cand <= sync_q;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            stable  <= cand;
            changed <= (cand != stable);
            state   <= STABLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= STABLE;
      endcase
    end
  end

endmodule

// File: rtl/gpio_io_unit.sv
// Pad-side GPIO stage: debounced input vector, registered output, optional
// rising-edge status/irq (GPIO_EDGE_IRQ_EN). rst is asynchronous, active-low.
module gpio_io_unit
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] cpu_gpio_in,
  output logic             in_changed,
  input  logic             gpio_we,
  input  logic [WIDTH-1:0] gpio_wdata,
  output logic [WIDTH-1:0] gpio_out,
  input  logic             irq_clr_we,
  input  logic [WIDTH-1:0] irq_clr,
  output logic             irq
);

  logic [WIDTH-1:0] rise;

  gpio_debounce #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .pad_in  (pad_in),
    .stable  (cpu_gpio_in),
    .changed (in_changed),
    .rise    (rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out <= '0;
    end else if (gpio_we) begin
      gpio_out <= gpio_wdata;
    end
  end

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] edge_status;
  logic [WIDTH-1:0] clr_mask;

  assign clr_mask = irq_clr_we ? irq_clr : '0;

  // A rise on the same edge as a clear keeps the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_status <= '0;
      irq         <= 1'b0;
    end else begin
      edge_status <= (edge_status & ~clr_mask) | rise;
      irq         <= |edge_status;
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_clr_we, irq_clr, rise};
  assign irq = 1'b0;
`endif

endmodule
